// File: rtl/rc5_ir_frontend.sv
// RC5 infrared receiver front end.
// Synchronises and de-glitches the raw receiver output, measures the width of
// each constant-level segment and classifies it as a 1T (short) or 2T (long)
// half-bit run, flagging widths that fit neither window. An idle flag marks
// the gap between frames; the first level change after idle marks frame start.
module rc5_ir_frontend #(
    parameter logic INVERT      = 1'b1,
    parameter int   FILTER_LEN  = 3,
    parameter int   CNT_W       = 8,
    parameter int   SHORT_MIN   = 20,
    parameter int   SHORT_MAX   = 36,
    parameter int   LONG_MIN    = 48,
    parameter int   LONG_MAX    = 64,
    parameter int   IDLE_CYCLES = 200
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ir,
    output logic o_level,
    output logic o_pulse_valid,
    output logic o_pulse_level,
    output logic o_pulse_long,
    output logic o_pulse_err,
    output logic o_idle
);

    localparam int FCNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [FCNT_W-1:0] F_LAST    = FCNT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0]  W_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  SHORT_LO  = CNT_W'(SHORT_MIN);
    localparam logic [CNT_W-1:0]  SHORT_HI  = CNT_W'(SHORT_MAX);
    localparam logic [CNT_W-1:0]  LONG_LO   = CNT_W'(LONG_MIN);
    localparam logic [CNT_W-1:0]  LONG_HI   = CNT_W'(LONG_MAX);
    localparam logic [CNT_W-1:0]  IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

    logic              ir_p0;
    logic              ir_p1;
    logic              s;
    logic [FCNT_W-1:0] fcnt;
    logic              toggle;
    logic [CNT_W-1:0]  w_cnt;

    // Width counter increment that sticks at full scale instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == W_MAX) ? v : v + 1'b1;
    endfunction

    // Segment classification, returned as {long, err}.
    function automatic logic [1:0] classify(input logic [CNT_W-1:0] w);
        if (w >= SHORT_LO && w <= SHORT_HI) begin
            return 2'b00;
        end else if (w >= LONG_LO && w <= LONG_HI) begin
            return 2'b10;
        end else begin
            return 2'b01;
        end
    endfunction

    // Active-high view of the synchronised input.
    assign s = ir_p1 ^ INVERT;

    // A level change is accepted once it has persisted for FILTER_LEN cycles.
    assign toggle = (s != o_level) && (fcnt == F_LAST);

    // Two-flop synchroniser; resets to the inactive raw level so release is quiet.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ir_p0 <= INVERT;
            ir_p1 <= INVERT;
        end else begin
            ir_p0 <= i_ir;
            ir_p1 <= ir_p0;
        end
    end

    // ---- stage boundary: synchronised sample -> filtered level ----
    // Glitch filter: count consecutive disagreeing cycles, flip the level on the last one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fcnt    <= '0;
            o_level <= 1'b0;
        end else begin
            if (s == o_level || toggle) begin
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
            o_level <= o_level ^ toggle;
        end
    end

    // ---- stage boundary: filtered level -> segment strobe / idle ----
    // Width measurement, segment classification and idle tracking.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            w_cnt         <= '0;
            o_idle        <= 1'b1;
            o_pulse_valid <= 1'b0;
            o_pulse_level <= 1'b0;
            o_pulse_long  <= 1'b0;
            o_pulse_err   <= 1'b0;
        end else begin
            o_pulse_valid <= 1'b0;
            o_pulse_level <= 1'b0;
            o_pulse_long  <= 1'b0;
            o_pulse_err   <= 1'b0;
            if (toggle) begin
                w_cnt  <= CNT_W'(1);
                o_idle <= 1'b0;
                // The toggle that ends idle is a frame start, not a segment end.
                if (!o_idle) begin
                    o_pulse_valid                <= 1'b1;
                    o_pulse_level                <= o_level;
                    {o_pulse_long, o_pulse_err}  <= classify(w_cnt);
                end
            end else begin
                w_cnt <= sat_inc(w_cnt);
                if (!o_idle && w_cnt == IDLE_LAST) begin
                    o_idle <= 1'b1;
                    // A carrier that never drops is reported once as a bad active segment.
                    if (o_level) begin
                        o_pulse_valid <= 1'b1;
                        o_pulse_level <= 1'b1;
                        o_pulse_err   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rc5_ir_frontend.sv
// Bench for rc5_ir_frontend: table of segments with expected strobes, hand
// sequences for glitch and asynchronous reset, then random segment traffic,
// with a cycle-level reference model checking every output on every cycle.
module tb_rc5_ir_frontend;

    localparam logic INVERT     = 1'b1;
    localparam int   FILTER_LEN = 3;
    localparam int   SYNC_LAT   = 2;
    localparam int   W_SAT      = 255;
    localparam int   IDLE       = 200;

    logic clk = 1'b0;
    logic i_rst;
    logic i_ir;
    logic o_level, o_pulse_valid, o_pulse_level, o_pulse_long, o_pulse_err, o_idle;

    int n_checks = 0;
    int n_fail   = 0;

    // strobes observed on the DUT since the counter was last cleared
    int   seg_strobes;
    logic last_lvl, last_lng, last_err;

    // reference model state
    logic raw_h[0:7];
    logic m_level, m_idle, m_pv, m_pl, m_plong, m_perr;
    int   m_w;

    rc5_ir_frontend dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_ir         (i_ir),
        .o_level      (o_level),
        .o_pulse_valid(o_pulse_valid),
        .o_pulse_level(o_pulse_level),
        .o_pulse_long (o_pulse_long),
        .o_pulse_err  (o_pulse_err),
        .o_idle       (o_idle)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) raw_h[i] = INVERT;
        m_level = 1'b0; m_idle = 1'b1; m_w = 0;
        m_pv = 1'b0; m_pl = 1'b0; m_plong = 1'b0; m_perr = 1'b0;
    endtask

    // Behaviour per clock edge: the level flips when the last FILTER_LEN
    // synchronised samples all disagree with it; segment width is the number of
    // edges since the previous flip.
    task automatic model_step(input logic ir);
        logic flip;
        for (int i = 7; i > 0; i--) raw_h[i] = raw_h[i-1];
        raw_h[0] = ir;
        flip = 1'b1;
        for (int i = 0; i < FILTER_LEN; i++)
            if ((raw_h[SYNC_LAT+i] ^ INVERT) == m_level) flip = 1'b0;
        m_pv = 1'b0; m_pl = 1'b0; m_plong = 1'b0; m_perr = 1'b0;
        if (flip) begin
            if (!m_idle) begin
                m_pv = 1'b1;
                m_pl = m_level;
                if (m_w >= 20 && m_w <= 36) m_plong = 1'b0;
                else if (m_w >= 48 && m_w <= 64) m_plong = 1'b1;
                else m_perr = 1'b1;
            end
            m_idle  = 1'b0;
            m_level = ~m_level;
            m_w     = 1;
        end else begin
            if (m_w < W_SAT) m_w = m_w + 1;
            if (!m_idle && m_w == IDLE) begin
                m_idle = 1'b1;
                if (m_level) begin
                    m_pv = 1'b1; m_pl = 1'b1; m_perr = 1'b1;
                end
            end
        end
    endtask

    // One clock: drive raw input, let the edge happen, compare all outputs.
    task automatic cyc(input logic ir);
        i_ir = ir;
        @(posedge clk);
        model_step(ir);
        #1;
        chk("cycle outputs {level,valid,plevel,long,err,idle}",
            {26'd0, o_level, o_pulse_valid, o_pulse_level, o_pulse_long, o_pulse_err, o_idle},
            {26'd0, m_level, m_pv, m_pl, m_plong, m_perr, m_idle});
        if (o_pulse_valid) begin
            seg_strobes++;
            last_lvl = o_pulse_level;
            last_lng = o_pulse_long;
            last_err = o_pulse_err;
        end
    endtask

    // Hold the line active (act=1) or inactive for len cycles.
    task automatic seg(input logic act, input int len);
        for (int i = 0; i < len; i++) cyc(act ^ INVERT);
    endtask

    typedef struct {
        logic act;
        int   len;
        int   n_strb;
        logic lvl;
        logic lng;
        logic err;
        logic idle;
    } vec_t;

    vec_t tbl[18];

    initial begin
        // act, len, strobes during segment, last strobe {level,long,err}, idle at end
        tbl[0]  = '{1'b1,  28, 0, 1'b0, 1'b0, 1'b0, 1'b0}; // idle exit, no strobe
        tbl[1]  = '{1'b0,  28, 1, 1'b1, 1'b0, 1'b0, 1'b0}; // active 28 -> short
        tbl[2]  = '{1'b1,  56, 1, 1'b0, 1'b0, 1'b0, 1'b0}; // inactive 28 -> short
        tbl[3]  = '{1'b0,  40, 1, 1'b1, 1'b1, 1'b0, 1'b0}; // active 56 -> long
        tbl[4]  = '{1'b1,  10, 1, 1'b0, 1'b0, 1'b1, 1'b0}; // 40 -> error
        tbl[5]  = '{1'b0,  30, 1, 1'b1, 1'b0, 1'b1, 1'b0}; // 10 -> error
        tbl[6]  = '{1'b1,  20, 1, 1'b0, 1'b0, 1'b0, 1'b0}; // 30 -> short
        tbl[7]  = '{1'b0,  36, 1, 1'b1, 1'b0, 1'b0, 1'b0}; // 20 -> short (low edge)
        tbl[8]  = '{1'b1,  48, 1, 1'b0, 1'b0, 1'b0, 1'b0}; // 36 -> short (high edge)
        tbl[9]  = '{1'b0,  64, 1, 1'b1, 1'b1, 1'b0, 1'b0}; // 48 -> long (low edge)
        tbl[10] = '{1'b1,  47, 1, 1'b0, 1'b1, 1'b0, 1'b0}; // 64 -> long (high edge)
        tbl[11] = '{1'b0,  19, 1, 1'b1, 1'b0, 1'b1, 1'b0}; // 47 -> error
        tbl[12] = '{1'b1,  37, 1, 1'b0, 1'b0, 1'b1, 1'b0}; // 19 -> error
        tbl[13] = '{1'b0,  65, 1, 1'b1, 1'b0, 1'b1, 1'b0}; // 37 -> error
        tbl[14] = '{1'b1,  30, 1, 1'b0, 1'b0, 1'b1, 1'b0}; // 65 -> error
        tbl[15] = '{1'b0, 230, 1, 1'b1, 1'b0, 1'b0, 1'b1}; // 30 short, then idle quietly
        tbl[16] = '{1'b1, 250, 1, 1'b1, 1'b0, 1'b1, 1'b1}; // frame start, stuck active
        tbl[17] = '{1'b0,  30, 0, 1'b0, 1'b0, 1'b0, 1'b0}; // leaves idle, no strobe

        // power-on reset
        i_rst = 1'b1;
        i_ir  = INVERT;
        seg_strobes = 0;
        last_lvl = 1'b0; last_lng = 1'b0; last_err = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs {level,valid,plevel,long,err,idle}",
            {26'd0, o_level, o_pulse_valid, o_pulse_level, o_pulse_long, o_pulse_err, o_idle},
            32'h01);
        i_rst = 1'b0;

        // table-driven segments
        for (int i = 0; i < 18; i++) begin
            seg_strobes = 0;
            seg(tbl[i].act, tbl[i].len);
            chk($sformatf("seg%0d strobe count", i), seg_strobes, tbl[i].n_strb);
            chk($sformatf("seg%0d idle", i), {31'd0, o_idle}, {31'd0, tbl[i].idle});
            if (tbl[i].n_strb > 0)
                chk($sformatf("seg%0d strobe {level,long,err}", i),
                    {29'd0, last_lvl, last_lng, last_err},
                    {29'd0, tbl[i].lvl, tbl[i].lng, tbl[i].err});
        end

        // glitch inside an active segment: width must span the glitch
        seg(1'b1, 15);
        seg_strobes = 0;
        seg(1'b0, 2);
        seg(1'b1, 15);
        chk("glitch strobe count", seg_strobes, 0);
        chk("glitch level held", {31'd0, o_level}, 32'd1);
        seg_strobes = 0;
        seg(1'b0, 20);
        chk("post-glitch strobe count", seg_strobes, 1);
        chk("post-glitch strobe {level,long,err}",
            {29'd0, last_lvl, last_lng, last_err}, 32'b100);

        // asynchronous reset mid-segment, asserted and released between edges
        seg(1'b1, 20);
        #3;
        i_rst = 1'b1;
        #1;
        chk("async reset outputs {level,valid,plevel,long,err,idle}",
            {26'd0, o_level, o_pulse_valid, o_pulse_level, o_pulse_long, o_pulse_err, o_idle},
            32'h01);
        model_reset();
        @(posedge clk);
        #2;
        chk("reset held across edge {level,idle}", {30'd0, o_level, o_idle}, 32'b01);
        i_rst = 1'b0;
        seg_strobes = 0;
        seg(1'b1, 20);
        chk("after reset release strobe count", seg_strobes, 0);
        chk("after reset release level", {31'd0, o_level}, 32'd1);
        seg_strobes = 0;
        seg(1'b0, 30);
        chk("after reset first strobe count", seg_strobes, 1);
        chk("after reset first strobe {level,long,err}",
            {29'd0, last_lvl, last_lng, last_err}, 32'b100);

        // random segment traffic against the model
        for (int k = 0; k < 60; k++) begin
            logic act;
            int   len;
            act = logic'($urandom_range(0, 1));
            len = $urandom_range(1, 80);
            if ($urandom_range(0, 9) == 0) len = 260;
            seg(act, len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
